// File: rtl/tilelink_ad_responder.sv
// TileLink-UL/UH A-to-D slave responder: queues A requests and answers them in order on D,
// with multi-beat bursts, error responses and externally driven stalls and read data.
module tilelink_ad_responder #(
  parameter int DATA_W   = 32,
  parameter int SRC_W    = 1,
  parameter int SIZE_W   = 4,
  parameter int DEPTH    = 2,
  parameter int MAX_SIZE = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall_a,
  input  logic                         stall_d,
  input  logic [DATA_W-1:0]            rdata,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [2:0]                   a_opcode,
  input  logic [2:0]                   a_param,
  input  logic [SIZE_W-1:0]            a_size,
  input  logic [SRC_W-1:0]             a_source,
  input  logic [31:0]                  a_address,
  input  logic [DATA_W/8-1:0]          a_mask,
  input  logic [DATA_W-1:0]            a_data,
  output logic                         d_valid,
  input  logic                         d_ready,
  output logic [2:0]                   d_opcode,
  output logic [1:0]                   d_param,
  output logic [SIZE_W-1:0]            d_size,
  output logic [SRC_W-1:0]             d_source,
  output logic [SRC_W-1:0]             d_sink,
  output logic [DATA_W-1:0]            d_data,
  output logic                         d_error,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int LOG_BYTES = $clog2(DATA_W / 8);
  localparam int OCC_W     = $clog2(DEPTH + 1);
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than 8 so a 1 KiB burst on a 32-bit bus (256 beats) still fits.
  localparam int BEAT_W    = 9;

  function automatic logic [BEAT_W-1:0] f_beats(input logic [SIZE_W-1:0] size);
    if (int'(size) > MAX_SIZE || int'(size) <= LOG_BYTES)
      return BEAT_W'(1);
    else
      return BEAT_W'(1) << (int'(size) - LOG_BYTES);
  endfunction

  logic [2:0]        r_q_op   [DEPTH];
  logic [SIZE_W-1:0] r_q_size [DEPTH];
  logic [SRC_W-1:0]  r_q_src  [DEPTH];
  logic              r_q_err  [DEPTH];

  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [OCC_W-1:0]  r_count;
  logic [BEAT_W-1:0] r_a_cnt, r_d_cnt;

  logic              w_a_multi, w_a_err, w_a_last, w_a_fire, w_push;
  logic [BEAT_W-1:0] w_a_beats, w_d_beats;
  logic [2:0]        w_h_op, w_h_dop;
  logic              w_h_data_resp, w_h_err;
  logic              w_empty, w_full, w_d_fire, w_pop;
  logic              w_unused;

  assign w_unused = ^{a_param, a_address, a_mask, a_data};

  // Put and Atomic requests carry write data, so only they span several A beats.
  assign w_a_multi = (a_opcode <= 3'd3);
  assign w_a_err   = (int'(a_size) > MAX_SIZE);
  assign w_a_beats = w_a_multi ? f_beats(a_size) : BEAT_W'(1);
  assign w_a_last  = (r_a_cnt == w_a_beats - BEAT_W'(1));
  assign w_a_fire  = a_valid && a_ready;
  assign w_push    = w_a_fire && w_a_last;

  assign w_h_op        = r_q_op[r_rptr];
  assign w_h_data_resp = (w_h_op == 3'd4) || (w_h_op == 3'd2) || (w_h_op == 3'd3);
  assign w_h_err       = r_q_err[r_rptr] || (w_h_op >= 3'd6);
  assign w_d_beats     = w_h_data_resp ? f_beats(r_q_size[r_rptr]) : BEAT_W'(1);

  always_comb begin
    w_h_dop = 3'd0;
    case (w_h_op)
      3'd2, 3'd3, 3'd4: w_h_dop = 3'd1;
      3'd5:             w_h_dop = 3'd2;
      default:          w_h_dop = 3'd0;
    endcase
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == OCC_W'(DEPTH));
  assign d_valid  = !reset && !stall_d && !w_empty;
  assign w_d_fire = d_valid && d_ready;
  assign w_pop    = w_d_fire && (r_d_cnt == w_d_beats - BEAT_W'(1));
  // A full queue still accepts when the head retires this same cycle.
  assign a_ready  = !reset && !stall_a && (r_a_cnt != '0 || !w_full || w_pop);

  always_comb begin
    d_opcode = '0;
    d_param  = '0;
    d_size   = '0;
    d_source = '0;
    d_sink   = '0;
    d_data   = '0;
    d_error  = 1'b0;
    if (d_valid) begin
      d_opcode = w_h_dop;
      d_size   = r_q_size[r_rptr];
      d_source = r_q_src[r_rptr];
      d_error  = w_h_err;
      if (w_h_dop == 3'd1) d_data = rdata;
    end
  end

  assign outstanding = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_cnt <= '0;
      r_d_cnt <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_a_fire) r_a_cnt <= w_a_last ? '0 : r_a_cnt + BEAT_W'(1);
      if (w_d_fire) r_d_cnt <= w_pop ? '0 : r_d_cnt + BEAT_W'(1);
      if (w_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_op[r_wptr]   <= a_opcode;
      r_q_size[r_wptr] <= a_size;
      r_q_src[r_wptr]  <= a_source;
      r_q_err[r_wptr]  <= w_a_err;
    end
  end

endmodule

// File: tb/tb_tilelink_ad_responder.sv
// Bench for tilelink_ad_responder: table of single transactions, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_tilelink_ad_responder;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_SIZE = 6;

  logic        clock = 1'b0;
  logic        reset, stall_a, stall_d, a_valid, d_ready;
  logic [31:0] rdata, a_address, a_data;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_mask;
  logic [0:0]  a_source;
  logic        a_ready, d_valid, d_error;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [0:0]  d_source, d_sink;
  logic [31:0] d_data;
  logic [1:0]  outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  tilelink_ad_responder #(
    .DATA_W(DATA_W), .SRC_W(1), .SIZE_W(4), .DEPTH(DEPTH), .MAX_SIZE(MAX_SIZE)
  ) dut (
    .clock(clock), .reset(reset), .stall_a(stall_a), .stall_d(stall_d), .rdata(rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_param(d_param), .d_size(d_size), .d_source(d_source), .d_sink(d_sink),
    .d_data(d_data), .d_error(d_error), .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] d_all();
    return {20'h0, d_opcode, d_param, d_size, d_source, d_sink, d_error, d_data};
  endfunction

  // Reference model derived from the protocol rules, not from the RTL structure.
  function automatic int m_beats(input int size);
    int b;
    if (size > MAX_SIZE) return 1;
    b = (1 << size) / (DATA_W / 8);
    return (b < 1) ? 1 : b;
  endfunction
  function automatic int m_a_beats(input int op, input int size);
    return (op <= 3) ? m_beats(size) : 1;
  endfunction
  function automatic int m_d_beats(input int op, input int size);
    return (op == 2 || op == 3 || op == 4) ? m_beats(size) : 1;
  endfunction
  function automatic logic [2:0] m_dop(input int op);
    if (op == 2 || op == 3 || op == 4) return 3'd1;
    if (op == 5) return 3'd2;
    return 3'd0;
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [3:0] size;
    logic [0:0] src;
    logic [2:0] dop;
    int         a_beats;
    int         d_beats;
    logic       err;
  } vec_t;

  typedef struct {
    logic [2:0] dop;
    logic [3:0] size;
    logic [0:0] src;
    logic       err;
    int         nbeats;
  } resp_t;

  task automatic idle_inputs();
    stall_a = 0; stall_d = 0; a_valid = 0; d_ready = 1;
    a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; rdata = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int a_done = 0;
    int d_done = 0;
    for (int cyc = 0; cyc < 64 && d_done < v.d_beats; cyc++) begin
      a_valid = (a_done < v.a_beats);
      a_opcode = v.op; a_size = v.size; a_source = v.src;
      a_data = $urandom; a_address = $urandom;
      d_ready = 1; stall_a = 0; stall_d = 0; rdata = $urandom;
      #1;
      if (a_valid) chk({tag, "_a_ready"}, a_ready, 1);
      if (d_valid) begin
        chk({tag, "_d_after_last_a"}, a_done, v.a_beats);
        chk({tag, "_d_opcode"}, d_opcode, v.dop);
        chk({tag, "_d_size"}, d_size, v.size);
        chk({tag, "_d_source"}, d_source, v.src);
        chk({tag, "_d_error"}, d_error, v.err);
        chk({tag, "_d_data"}, d_data, (v.dop == 3'd1) ? rdata : 32'h0);
        d_done++;
      end
      if (a_valid && a_ready) a_done++;
      tick();
    end
    chk({tag, "_d_beats"}, d_done, v.d_beats);
    a_valid = 0;
    #1;
    chk({tag, "_end_d_valid"}, d_valid, 0);
    chk({tag, "_end_outstanding"}, outstanding, 0);
    tick();
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{op:3'd4, size:4'd4, src:1'b1, dop:3'd1, a_beats:1, d_beats:4,  err:1'b0};
    vecs[1]  = '{op:3'd0, size:4'd3, src:1'b0, dop:3'd0, a_beats:2, d_beats:1,  err:1'b0};
    vecs[2]  = '{op:3'd1, size:4'd2, src:1'b1, dop:3'd0, a_beats:1, d_beats:1,  err:1'b0};
    vecs[3]  = '{op:3'd2, size:4'd3, src:1'b0, dop:3'd1, a_beats:2, d_beats:2,  err:1'b0};
    vecs[4]  = '{op:3'd3, size:4'd0, src:1'b1, dop:3'd1, a_beats:1, d_beats:1,  err:1'b0};
    vecs[5]  = '{op:3'd5, size:4'd5, src:1'b0, dop:3'd2, a_beats:1, d_beats:1,  err:1'b0};
    vecs[6]  = '{op:3'd6, size:4'd2, src:1'b1, dop:3'd0, a_beats:1, d_beats:1,  err:1'b1};
    vecs[7]  = '{op:3'd7, size:4'd2, src:1'b0, dop:3'd0, a_beats:1, d_beats:1,  err:1'b1};
    vecs[8]  = '{op:3'd4, size:4'd7, src:1'b1, dop:3'd1, a_beats:1, d_beats:1,  err:1'b1};
    vecs[9]  = '{op:3'd0, size:4'd7, src:1'b0, dop:3'd0, a_beats:1, d_beats:1,  err:1'b1};
    vecs[10] = '{op:3'd4, size:4'd6, src:1'b0, dop:3'd1, a_beats:1, d_beats:16, err:1'b0};

    // Reset state, with a request and d_ready already presented.
    idle_inputs();
    reset = 1;
    tick();
    a_valid = 1; a_opcode = 3'd4; rdata = 32'hdeadbeef;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_fields", d_all(), 0);
    chk("rst_outstanding", outstanding, 0);
    tick();
    reset = 0; a_valid = 0;
    #1;
    chk("post_rst_d_valid", d_valid, 0);
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_outstanding", outstanding, 0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: fill the queue, then accept the third request alongside the first pop.
    a_valid = 1; a_opcode = 3'd4; a_size = 4'd2; a_source = 0; d_ready = 0;
    #1; chk("bp_accept1", a_ready, 1);
    tick();
    a_source = 1;
    #1; chk("bp_accept2", a_ready, 1); chk("bp_occ1", outstanding, 1);
    chk("bp_dvalid", d_valid, 1);
    tick();
    a_source = 0;
    #1; chk("bp_full_occ", outstanding, 2); chk("bp_full_block", a_ready, 0);
    d_ready = 1;
    #1; chk("bp_pop_accept", a_ready, 1); chk("bp_src_first", d_source, 0);
    tick();
    a_valid = 0;
    #1; chk("bp_occ_swap", outstanding, 2); chk("bp_src_second", d_source, 1);
    tick();
    #1; chk("bp_occ_drain", outstanding, 1); chk("bp_src_third", d_source, 0);
    tick();
    #1; chk("bp_empty", outstanding, 0); chk("bp_empty_dvalid", d_valid, 0);
    tick();

    // stall_d toggling through a 4-beat Get.
    begin
      int beats = 0;
      a_valid = 1; a_opcode = 3'd4; a_size = 4'd4; a_source = 1; d_ready = 1;
      #1; chk("stall_accept", a_ready, 1);
      tick();
      a_valid = 0;
      for (int i = 0; i < 20; i++) begin
        stall_d = (i % 2 == 0);
        rdata = $urandom;
        #1;
        chk("stall_d_valid", d_valid, !stall_d && beats < 4);
        if (d_valid) begin
          chk("stall_d_data", d_data, rdata);
          chk("stall_d_opcode", d_opcode, 3'd1);
          beats++;
        end
        tick();
      end
      stall_d = 0;
      chk("stall_beats", beats, 4);
      chk("stall_outstanding", outstanding, 0);
    end

    // Reset after two beats of a 4-beat Get, then an Intent.
    a_valid = 1; a_opcode = 3'd4; a_size = 4'd4; a_source = 0; d_ready = 1;
    tick();
    a_valid = 0;
    #1; chk("midrst_beat1", d_valid, 1);
    tick();
    tick();
    reset = 1;
    #1; chk("midrst_a_ready", a_ready, 0); chk("midrst_d_fields", d_all(), 0);
    tick();
    reset = 0;
    #1; chk("midrst_occ", outstanding, 0); chk("midrst_d_valid", d_valid, 0);
    run_vec(vecs[5], "midrst_intent");

    // Randomized traffic against the queue model.
    begin
      resp_t q[$];
      resp_t r;
      int m_a = 0, m_d = 0, cur_ab;
      logic [2:0] cur_op;
      logic [3:0] cur_size;
      logic [0:0] cur_src;
      logic exp_dv, exp_ar, pop;
      cur_op = 3'($urandom_range(0, 7)); cur_size = 4'($urandom_range(0, 7));
      cur_src = 1'($urandom_range(0, 1));
      cur_ab = m_a_beats(int'(cur_op), int'(cur_size));
      for (int c = 0; c < 3000; c++) begin
        stall_a = ($urandom_range(0, 3) == 0);
        stall_d = ($urandom_range(0, 3) == 0);
        d_ready = ($urandom_range(0, 3) != 0);
        a_valid = ($urandom_range(0, 2) != 0);
        a_opcode = cur_op; a_size = cur_size; a_source = cur_src;
        a_param = 3'($urandom); a_address = $urandom; a_mask = 4'($urandom);
        a_data = $urandom; rdata = $urandom;
        #1;
        exp_dv = !stall_d && q.size() > 0;
        pop = exp_dv && d_ready && (m_d == q[0].nbeats - 1);
        exp_ar = !stall_a && (m_a != 0 || q.size() < DEPTH || pop);
        chk("rnd_a_ready", a_ready, exp_ar);
        chk("rnd_d_valid", d_valid, exp_dv);
        chk("rnd_outstanding", outstanding, q.size());
        if (exp_dv) begin
          chk("rnd_d_head", {d_opcode, d_param, d_size, d_source, d_sink, d_error},
              {q[0].dop, 2'b00, q[0].size, q[0].src, 1'b0, q[0].err});
          chk("rnd_d_data", d_data, (q[0].dop == 3'd1) ? rdata : 32'h0);
        end else begin
          chk("rnd_d_idle", d_all(), 0);
        end
        if (exp_dv && d_ready) begin
          if (pop) begin void'(q.pop_front()); m_d = 0; end
          else m_d++;
        end
        if (a_valid && exp_ar) begin
          if (m_a == cur_ab - 1) begin
            r.dop = m_dop(int'(cur_op));
            r.size = cur_size;
            r.src = cur_src;
            r.err = (int'(cur_size) > MAX_SIZE) || (cur_op >= 3'd6);
            r.nbeats = m_d_beats(int'(cur_op), int'(cur_size));
            q.push_back(r);
            m_a = 0;
            cur_op = 3'($urandom_range(0, 7)); cur_size = 4'($urandom_range(0, 7));
            cur_src = 1'($urandom_range(0, 1));
            cur_ab = m_a_beats(int'(cur_op), int'(cur_size));
          end else begin
            m_a++;
          end
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
